// File: rtl/uart_line_pkg.sv
// Shared constants, types and byte classification for the UART line collector.
package uart_line_pkg;

  localparam int unsigned c_line_bytes = 34;
  localparam int unsigned c_line_chars = 32;
  localparam logic [5:0]  c_max_count  = 6'd32;

  localparam logic [7:0] c_ascii_cr  = 8'h0D;
  localparam logic [7:0] c_ascii_lf  = 8'h0A;
  localparam logic [7:0] c_ascii_bs  = 8'h08;
  localparam logic [7:0] c_ascii_del = 8'h7F;
  localparam logic [7:0] c_ascii_sp  = 8'h20;

  localparam logic [c_line_bytes*8-1:0] c_line_of_spaces =
      {{c_line_chars{c_ascii_sp}}, c_ascii_cr, c_ascii_lf};

  typedef enum logic [1:0] {
    StRxlineCollect,
    StRxlineDiscard,
    StRxlinePresent
  } t_rxline_state;

  typedef enum logic [1:0] {
    ChPrint,
    ChTerm,
    ChBackspace,
    ChOther
  } t_char_class;

  function automatic t_char_class classify_char(input logic [7:0] b);
    if (b >= c_ascii_sp && b < c_ascii_del) begin
      return ChPrint;
    end else if (b == c_ascii_cr || b == c_ascii_lf) begin
      return ChTerm;
    end else if (b == c_ascii_bs || b == c_ascii_del) begin
      return ChBackspace;
    end else begin
      return ChOther;
    end
  endfunction

endpackage

// File: rtl/uart_rx_line_collect.sv
// Assembles received UART bytes into a fixed 32-char + CR LF line with backspace
// editing and overflow truncation; the finished line is offered on valid/ready.
module uart_rx_line_collect
  import uart_line_pkg::*;
(
  input  logic                      i_clk_20mhz,
  input  logic                      i_rstn_20mhz,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic [c_line_bytes*8-1:0] o_line_ascii,
  output logic [5:0]                o_line_len,
  output logic                      o_line_trunc,
  output logic                      o_line_valid,
  input  logic                      i_line_ready,
  output logic                      o_rx_drop
);

  t_rxline_state state_q, state_d;
  logic [7:0]    buf_q [c_line_chars];
  logic [7:0]    buf_d [c_line_chars];
  logic [5:0]    count_q, count_d;
  logic          trunc_q, trunc_d;
  logic          drop_q, drop_d;
  t_char_class   cls;
  logic [4:0]    last_idx;

  assign cls      = classify_char(i_rx_data);
  // Wraps to 31 when count is 32, which is exactly the last stored char.
  assign last_idx = count_q[4:0] - 5'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    trunc_d = trunc_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StRxlineCollect: begin
        if (i_rx_valid) begin
          unique case (cls)
            ChPrint: begin
              if (count_q == c_max_count) begin
                trunc_d = 1'b1;
                state_d = StRxlineDiscard;
              end else begin
                buf_d[count_q[4:0]] = i_rx_data;
                count_d             = count_q + 6'd1;
              end
            end
            ChBackspace: begin
              if (count_q != 6'd0) begin
                buf_d[last_idx] = c_ascii_sp;
                count_d         = count_q - 6'd1;
              end
            end
            ChTerm: begin
              if (count_q != 6'd0) begin
                state_d = StRxlinePresent;
              end
            end
            default: ;
          endcase
        end
      end
      StRxlineDiscard: begin
        if (i_rx_valid && cls == ChTerm) begin
          state_d = StRxlinePresent;
        end
      end
      StRxlinePresent: begin
        // Bytes arriving in the handshake cycle are still dropped.
        if (i_rx_valid && (cls == ChPrint || cls == ChBackspace)) begin
          drop_d = 1'b1;
        end
        if (i_line_ready) begin
          for (int i = 0; i < c_line_chars; i++) begin
            buf_d[i] = c_ascii_sp;
          end
          count_d = 6'd0;
          trunc_d = 1'b0;
          state_d = StRxlineCollect;
        end
      end
      default: state_d = StRxlineCollect;
    endcase
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q <= StRxlineCollect;
      for (int i = 0; i < c_line_chars; i++) begin
        buf_q[i] <= c_ascii_sp;
      end
      count_q <= 6'd0;
      trunc_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    o_line_ascii = c_line_of_spaces;
    for (int i = 0; i < c_line_chars; i++) begin
      o_line_ascii[c_line_bytes*8-1-8*i -: 8] = buf_q[i];
    end
  end

  assign o_line_len   = count_q;
  assign o_line_trunc = trunc_q;
  assign o_line_valid = (state_q == StRxlinePresent);
  assign o_rx_drop    = drop_q;

endmodule
